// File: rtl/rv32_decode_stage.sv
// RV32I decode and operand-fetch stage.
// S1 holds an instruction while its register-file read is in flight; S2 is the
// output register toward execute. Same-cycle writebacks are either forwarded
// into the captured operands or cause S1 to wait one cycle.
// Optional feature macro: WB_BYPASS_EN (writeback forwarding instead of hold).

module rv32_decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_flush,

    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,

    output logic [4:0]      o_rs_addr_1,
    output logic [4:0]      o_rs_addr_2,
    output logic            o_rf_renable,
    input  logic [XLEN-1:0] i_rs_val1,
    input  logic [XLEN-1:0] i_rs_val2,

    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_val,

    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_rs1_val,
    output logic [XLEN-1:0] o_rs2_val,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_rd,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic            o_funct7b5,
    output logic            o_illegal
);

    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    logic            s1_valid_q, s1_valid_d;
    logic [31:0]     s1_instr_q;
    logic [XLEN-1:0] s1_pc_q;
    logic            o_valid_d;

    logic            accept;
    logic            s1_adv;
    logic            hold;
    logic [4:0]      s1_rs1;
    logic [4:0]      s1_rs2;
    logic [6:0]      s1_op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [31:0]     imm;
    logic            illegal;

    assign s1_rs1 = s1_instr_q[19:15];
    assign s1_rs2 = s1_instr_q[24:20];
    assign s1_op  = s1_instr_q[6:0];

    // Register-file addresses come straight from the offered instruction.
    assign o_rs_addr_1 = i_instr[19:15];
    assign o_rs_addr_2 = i_instr[24:20];

`ifdef WB_BYPASS_EN
    assign hold = 1'b0;
`else
    // Without forwarding, wait a cycle so the register file shows the new value.
    assign hold = i_wb_we && (i_wb_rd != 5'd0) &&
                  ((i_wb_rd == s1_rs1) || (i_wb_rd == s1_rs2));
    logic unused_wb_val;
    assign unused_wb_val = ^i_wb_val;
`endif

    assign s1_adv       = s1_valid_q && (!o_valid || i_ready) && !hold;
    assign o_ready      = !i_flush && (!s1_valid_q || s1_adv);
    assign accept       = i_valid && o_ready;
    assign o_rf_renable = accept;

    // Operand select: forward a matching writeback, and x0 always reads as zero.
    always_comb begin
        op1 = i_rs_val1;
        op2 = i_rs_val2;
`ifdef WB_BYPASS_EN
        if (i_wb_we && (i_wb_rd != 5'd0) && (i_wb_rd == s1_rs1)) op1 = i_wb_val;
        if (i_wb_we && (i_wb_rd != 5'd0) && (i_wb_rd == s1_rs2)) op2 = i_wb_val;
`endif
        if (s1_rs1 == 5'd0) op1 = '0;
        if (s1_rs2 == 5'd0) op2 = '0;
    end

    // Immediate extraction by instruction format.
    always_comb begin
        imm = '0;
        case (s1_op)
            OpImm, OpLoad, OpJalr:
                imm = {{20{s1_instr_q[31]}}, s1_instr_q[31:20]};
            OpStore:
                imm = {{20{s1_instr_q[31]}}, s1_instr_q[31:25], s1_instr_q[11:7]};
            OpBranch:
                imm = {{19{s1_instr_q[31]}}, s1_instr_q[31], s1_instr_q[7],
                       s1_instr_q[30:25], s1_instr_q[11:8], 1'b0};
            OpLui, OpAuipc:
                imm = {s1_instr_q[31:12], 12'b0};
            OpJal:
                imm = {{11{s1_instr_q[31]}}, s1_instr_q[31], s1_instr_q[19:12],
                       s1_instr_q[20], s1_instr_q[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    // Illegal-opcode flag; the instruction still flows to execute.
    always_comb begin
        illegal = 1'b1;
        case (s1_op)
            OpImm, OpLoad, OpJalr, OpStore, OpBranch, OpLui, OpAuipc, OpJal,
            OpReg, OpFence, OpSystem: illegal = 1'b0;
            default:                  illegal = 1'b1;
        endcase
        if (s1_instr_q[1:0] != 2'b11) illegal = 1'b1;
    end

    // Next-state of both valid bits; flush has the last word.
    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_adv) s1_valid_d = 1'b0;
        if (accept) s1_valid_d = 1'b1;
        if (i_flush) s1_valid_d = 1'b0;

        o_valid_d = o_valid;
        if (o_valid && i_ready) o_valid_d = 1'b0;
        if (s1_adv) o_valid_d = 1'b1;
        if (i_flush) o_valid_d = 1'b0;
    end

    // S1: instruction whose register-file read is in flight.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s1_pc_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_instr_q <= i_instr;
                s1_pc_q    <= i_pc;
            end
        end
    end

    // S2: output register toward execute, loaded only on advance.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_rs1_val  <= '0;
            o_rs2_val  <= '0;
            o_imm      <= '0;
            o_rd       <= '0;
            o_opcode   <= '0;
            o_funct3   <= '0;
            o_funct7b5 <= 1'b0;
            o_illegal  <= 1'b0;
        end else begin
            o_valid <= o_valid_d;
            if (s1_adv) begin
                o_pc       <= s1_pc_q;
                o_rs1_val  <= op1;
                o_rs2_val  <= op2;
                o_imm      <= imm;
                o_rd       <= s1_instr_q[11:7];
                o_opcode   <= s1_op;
                o_funct3   <= s1_instr_q[14:12];
                o_funct7b5 <= s1_instr_q[30];
                o_illegal  <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Self-checking bench for rv32_decode_stage: directed scenarios followed by
// random traffic scored against an architectural reference model.

module tb_rv32_decode_stage;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [4:0]  o_rs_addr_1;
    logic [4:0]  o_rs_addr_2;
    logic        o_rf_renable;
    logic [31:0] i_rs_val1;
    logic [31:0] i_rs_val2;
    logic        i_wb_we;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_val;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc;
    logic [31:0] o_rs1_val;
    logic [31:0] o_rs2_val;
    logic [31:0] o_imm;
    logic [4:0]  o_rd;
    logic [6:0]  o_opcode;
    logic [2:0]  o_funct3;
    logic        o_funct7b5;
    logic        o_illegal;

    always #5 clk = ~clk;

    rv32_decode_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_instr      (i_instr),
        .i_pc         (i_pc),
        .o_rs_addr_1  (o_rs_addr_1),
        .o_rs_addr_2  (o_rs_addr_2),
        .o_rf_renable (o_rf_renable),
        .i_rs_val1    (i_rs_val1),
        .i_rs_val2    (i_rs_val2),
        .i_wb_we      (i_wb_we),
        .i_wb_rd      (i_wb_rd),
        .i_wb_val     (i_wb_val),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_pc         (o_pc),
        .o_rs1_val    (o_rs1_val),
        .o_rs2_val    (o_rs2_val),
        .o_imm        (o_imm),
        .o_rd         (o_rd),
        .o_opcode     (o_opcode),
        .o_funct3     (o_funct3),
        .o_funct7b5   (o_funct7b5),
        .o_illegal    (o_illegal)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register file: address latched on read enable, data one cycle later.
    // x0 deliberately holds junk so the stage's own zeroing is exercised.
    logic [31:0] rf [32];
    logic [4:0]  ra1, ra2;
    always @(posedge clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(10 * i);
            rf[0] <= 32'hBAD0_0000;
            ra1   <= 5'd0;
            ra2   <= 5'd0;
        end else begin
            if (i_wb_we) rf[i_wb_rd] <= i_wb_val;
            if (o_rf_renable) begin
                ra1 <= o_rs_addr_1;
                ra2 <= o_rs_addr_2;
            end
        end
    end
    assign i_rs_val1 = rf[ra1];
    assign i_rs_val2 = rf[ra2];

    // Architectural value of a register as execute must see it.
    function automatic logic [31:0] reg_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : rf[a];
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic [31:0] s20, s19, s11;
        s20 = $unsigned($signed(ins) >>> 20);
        s19 = $unsigned($signed(ins) >>> 19);
        s11 = $unsigned($signed(ins) >>> 11);
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: return s20;
            7'b0100011: return (s20 & ~32'h1F) | 32'(ins[11:7]);
            7'b1100011: return (s19 & 32'hFFFF_F000) | (32'(ins[7]) << 11) |
                               (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            7'b0110111, 7'b0010111: return ins & 32'hFFFF_F000;
            7'b1101111: return (s11 & 32'hFFF0_0000) | (ins & 32'h000F_F000) |
                               (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [31:0] ins);
        return !(ins[6:0] inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                  7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                  7'b0110011, 7'b0001111, 7'b1110011});
    endfunction

    // Scoreboard: accepted instructions in order; operands are the register
    // contents at the moment the instruction first shows up at the output.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    item_t       exp_q[$];
    item_t       cur;
    logic        have_cur = 1'b0;
    logic [31:0] cur_r1, cur_r2;
    int          n_accepted = 0;

    always @(negedge clk) begin
        if (!i_rst_n) begin
            exp_q.delete();
            have_cur = 1'b0;
        end else begin
            check("rs_addr_1", 32'(o_rs_addr_1), 32'(i_instr[19:15]));
            check("rs_addr_2", 32'(o_rs_addr_2), 32'(i_instr[24:20]));
            if (o_valid) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 32'(o_valid), 32'd0);
                    end else begin
                        cur      = exp_q.pop_front();
                        cur_r1   = reg_val(cur.instr[19:15]);
                        cur_r2   = reg_val(cur.instr[24:20]);
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    check("sb_pc", o_pc, cur.pc);
                    check("sb_rs1_val", o_rs1_val, cur_r1);
                    check("sb_rs2_val", o_rs2_val, cur_r2);
                    check("sb_imm", o_imm, ref_imm(cur.instr));
                    check("sb_rd", 32'(o_rd), 32'(cur.instr[11:7]));
                    check("sb_opcode", 32'(o_opcode), 32'(cur.instr[6:0]));
                    check("sb_funct3", 32'(o_funct3), 32'(cur.instr[14:12]));
                    check("sb_funct7b5", 32'(o_funct7b5), 32'(cur.instr[30]));
                    check("sb_illegal", 32'(o_illegal), 32'(ref_illegal(cur.instr)));
                end
                if (i_ready) have_cur = 1'b0;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back('{instr: i_instr, pc: i_pc});
                n_accepted++;
            end
            if (i_flush) begin
                exp_q.delete();
                have_cur = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        i_valid = 1'b1;
        i_instr = ins;
        i_pc    = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [12];
        logic [31:0] ins;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111, 7'b1110011, 7'b0000000};
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 15) == 0) ins[6:0] = 7'($urandom);
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    localparam logic [31:0] AddiX3 = 32'hFFB0_8193;  // addi x3,x1,-5
    localparam logic [31:0] AddX5  = 32'h0073_02B3;  // add  x5,x6,x7
    localparam logic [31:0] SwX2   = 32'h0022_2423;  // sw   x2,8(x4)
    localparam logic [31:0] AddX0  = 32'h0000_02B3;  // add  x5,x0,x0
`ifdef WB_BYPASS_EN
    localparam int ExtraCycles = 0;
`else
    localparam int ExtraCycles = 1;
`endif

    int n;
    int idx;
    logic [31:0] t4_instr [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n  = 1'b0;
        i_flush  = 1'b0;
        i_valid  = 1'b0;
        i_instr  = 32'd0;
        i_pc     = 32'd0;
        i_wb_we  = 1'b0;
        i_wb_rd  = 5'd0;
        i_wb_val = 32'd0;
        i_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_ready", 32'(o_ready), 32'd1);
        check("rst_o_pc", o_pc, 32'd0);
        check("rst_o_imm", o_imm, 32'd0);
        check("rst_o_rs1_val", o_rs1_val, 32'd0);
        check("rst_o_rd", 32'(o_rd), 32'd0);
        check("rst_o_illegal", 32'(o_illegal), 32'd0);
        i_rst_n = 1'b1;

        // addi: two-cycle latency and its fields
        offer(AddiX3, 32'h100);
        @(negedge clk);
        check("t1_ready", 32'(o_ready), 32'd1);
        check("t1_renable", 32'(o_rf_renable), 32'd1);
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_early", 32'(o_valid), 32'd0);
        check("t1_renable_idle", 32'(o_rf_renable), 32'd0);
        tick();
        @(negedge clk);
        check("t1_valid", 32'(o_valid), 32'd1);
        check("t1_rs1_val", o_rs1_val, 32'd10);
        check("t1_imm", o_imm, 32'hFFFF_FFFB);
        check("t1_rd", 32'(o_rd), 32'd3);
        check("t1_illegal", 32'(o_illegal), 32'd0);
        tick();

        // back-to-back add then sw
        offer(AddX5, 32'h200);
        tick();
        offer(SwX2, 32'h204);
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        check("t2_valid_a", 32'(o_valid), 32'd1);
        check("t2_rs1_a", o_rs1_val, 32'd60);
        check("t2_rs2_a", o_rs2_val, 32'd70);
        tick();
        @(negedge clk);
        check("t2_valid_b", 32'(o_valid), 32'd1);
        check("t2_pc_b", o_pc, 32'h204);
        check("t2_rs1_b", o_rs1_val, 32'd40);
        check("t2_rs2_b", o_rs2_val, 32'd20);
        check("t2_imm_b", o_imm, 32'd8);
        tick();

        // writeback to x6 in the cycle add sits in S1
        offer(AddX5, 32'h300);
        tick();
        i_valid  = 1'b0;
        i_wb_we  = 1'b1;
        i_wb_rd  = 5'd6;
        i_wb_val = 32'h0000_DEAD;
        tick();
        i_wb_we = 1'b0;
        n = 0;
        @(negedge clk);
        while (!o_valid && n < 4) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("t3_extra_cycles", 32'(n), 32'(ExtraCycles));
        check("t3_rs1_val", o_rs1_val, 32'h0000_DEAD);
        check("t3_rs2_val", o_rs2_val, 32'd70);
        tick();

        // backpressure: three offered, only two fit
        t4_instr = '{AddiX3, AddX5, SwX2};
        i_ready = 1'b0;
        idx = 0;
        offer(t4_instr[0], 32'h400);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (o_ready) idx++;
            tick();
            if (idx < 3) offer(t4_instr[idx], 32'h400 + 32'(4 * idx));
            else i_valid = 1'b0;
        end
        @(negedge clk);
        check("t4_accepted", 32'(idx), 32'd2);
        check("t4_ready_low", 32'(o_ready), 32'd0);
        check("t4_pc_held", o_pc, 32'h400);
        tick();
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (i_valid && o_ready) idx++;
            tick();
            if (idx >= 3) i_valid = 1'b0;
        end
        check("t4_all_accepted", 32'(idx), 32'd3);

        // flush with two in flight
        i_ready = 1'b0;
        offer(AddiX3, 32'h500);
        tick();
        offer(AddX5, 32'h504);
        tick();
        offer(SwX2, 32'h508);
        i_flush = 1'b1;
        @(negedge clk);
        check("t5_ready_flush", 32'(o_ready), 32'd0);
        check("t5_valid_before", 32'(o_valid), 32'd1);
        tick();
        i_flush = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check("t5_valid_after", 32'(o_valid), 32'd0);
        check("t5_ready_after", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        check("t5_new_early", 32'(o_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t5_new_valid", 32'(o_valid), 32'd1);
        check("t5_new_pc", o_pc, 32'h508);
        tick();

        // all-zero word is illegal; x0 sources ignore a writeback to x0
        offer(32'h0000_0000, 32'h600);
        tick();
        i_valid = 1'b0;
        tick();
        @(negedge clk);
        check("t6_illegal", 32'(o_illegal), 32'd1);
        tick();
        offer(AddX0, 32'h604);
        tick();
        i_valid  = 1'b0;
        i_wb_we  = 1'b1;
        i_wb_rd  = 5'd0;
        i_wb_val = 32'h0000_1234;
        tick();
        i_wb_we = 1'b0;
        @(negedge clk);
        check("t6_x0_valid", 32'(o_valid), 32'd1);
        check("t6_x0_rs1", o_rs1_val, 32'd0);
        check("t6_x0_rs2", o_rs2_val, 32'd0);
        tick();

        // reset mid-operation, then accept right after release
        i_ready = 1'b0;
        offer(AddiX3, 32'h680);
        tick();
        offer(SwX2, 32'h684);
        tick();
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 32'(o_valid), 32'd0);
        check("t7_rst_pc", o_pc, 32'd0);
        check("t7_rst_imm", o_imm, 32'd0);
        check("t7_rst_rs2", o_rs2_val, 32'd0);
        tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        offer(AddiX3, 32'h700);
        @(negedge clk);
        check("t7_ready_release", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        tick();
        @(negedge clk);
        check("t7_valid", 32'(o_valid), 32'd1);
        check("t7_pc", o_pc, 32'h700);
        check("t7_rs1_val", o_rs1_val, 32'd10);
        tick();

        // random traffic
        n_accepted = 0;
        for (int c = 0; c < 2000; c++) begin
            i_valid  = ($urandom_range(0, 9) < 7);
            i_instr  = rand_instr();
            i_pc     = 32'h1_0000 + 32'(4 * c);
            i_ready  = ($urandom_range(0, 9) < 7);
            i_flush  = ($urandom_range(0, 49) == 0);
            i_wb_we  = ($urandom_range(0, 2) == 0);
            i_wb_rd  = 5'($urandom_range(0, 7));
            i_wb_val = $urandom;
            tick();
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_wb_we = 1'b0;
        i_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(o_valid), 32'd0);
        check("random_progress", 32'(n_accepted >= 500), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
